// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: converts two BCD digits (00..99) to a 7-bit binary value
// using the shift-right / subtract-3 (reverse double-dabble) method, one
// result bit per clock, with a start/ready/done_tick handshake.
module bcd_to_bin_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    output logic       ready,
    output logic       done_tick,
    output logic [6:0] bin
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  b1_q, b1_d;
    logic [3:0]  b0_q, b0_d;
    logic [6:0]  bin_q, bin_d;
    logic [2:0]  n_q, n_d;
    logic [14:0] shifted;

    // A digit that reads 8 or more after the right shift held an odd tens
    // weight from the digit above; subtracting 3 restores a valid BCD digit.
    function automatic logic [3:0] dabble_fix(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    // State and datapath registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            b1_q    <= 4'd0;
            b0_q    <= 4'd0;
            bin_q   <= 7'd0;
            n_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            b1_q    <= b1_d;
            b0_q    <= b0_d;
            bin_q   <= bin_d;
            n_q     <= n_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        b1_d      = b1_q;
        b0_d      = b0_q;
        bin_d     = bin_q;
        n_d       = n_q;
        ready     = 1'b0;
        done_tick = 1'b0;
        // Whole 15-bit {b1,b0,bin} shifted right, zero entering at the top.
        shifted   = {1'b0, b1_q, b0_q, bin_q[6:1]};

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    b1_d    = bcd1;
                    b0_d    = bcd0;
                    bin_d   = 7'd0;
                    n_d     = 3'd7;
                    state_d = OP;
                end
            end
            OP: begin
                b1_d  = dabble_fix(shifted[14:11]);
                b0_d  = dabble_fix(shifted[10:7]);
                bin_d = shifted[6:0];
                n_d   = n_q - 3'd1;
                // n==1 means this cycle writes the seventh and final shift.
                if (n_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_tick = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bin = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq: directed and randomized conversions checked
// against the arithmetic value tens*10 + units.
module tb_bcd_to_bin_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       ready;
    logic       done_tick;
    logic [6:0] bin;

    int total = 0;
    int bad   = 0;

    bcd_to_bin_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .ready     (ready),
        .done_tick (done_tick),
        .bin       (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_bin(input int t, input int u);
        int v;
        v = t * 10 + u;
        return v[6:0];
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion; optionally disturb inputs and pulse start mid-OP.
    task automatic run_conv(input int t, input int u, input bit disturb);
        logic [6:0] exp;
        exp = ref_bin(t, u);
        @(negedge clk);
        check("ready_before_start", {6'd0, ready}, 7'd1);
        bcd1  = t[3:0];
        bcd0  = u[3:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check("op_ready_low", {6'd0, ready}, 7'd0);
            check("op_no_done", {6'd0, done_tick}, 7'd0);
            if (disturb && k == 3) begin
                bcd1  = 4'(9 - t);
                bcd0  = 4'(9 - u);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_tick_high", {6'd0, done_tick}, 7'd1);
        check("done_ready_low", {6'd0, ready}, 7'd0);
        check("done_bin", bin, exp);
        @(negedge clk);
        check("idle_ready_back", {6'd0, ready}, 7'd1);
        check("idle_done_low", {6'd0, done_tick}, 7'd0);
        check("idle_bin_hold", bin, exp);
    endtask

    initial begin
        logic [6:0] cur_exp;
        logic [6:0] next_exp;
        int dcount;
        int t;
        int u;

        reset = 1'b1;
        start = 1'b0;
        bcd1  = 4'd0;
        bcd0  = 4'd0;
        repeat (250) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {6'd0, ready}, 7'd1);
        check("reset_done", {6'd0, done_tick}, 7'd0);
        check("reset_bin", bin, 7'd0);

        // Directed digit pairs including the range boundaries.
        run_conv(5, 5, 1'b0);
        run_conv(0, 0, 1'b0);
        run_conv(9, 9, 1'b0);
        run_conv(1, 0, 1'b0);
        run_conv(0, 9, 1'b0);

        // Inputs changed and start pulsed while converting.
        run_conv(4, 7, 1'b1);
        run_conv(9, 0, 1'b1);

        // Random valid digit pairs.
        for (int i = 0; i < 20; i++) begin
            run_conv(int'($urandom_range(9)), int'($urandom_range(9)), i[0]);
        end

        // Start held high: a new conversion every 9 cycles, new digits
        // presented during each one-cycle IDLE window.
        @(negedge clk);
        t = int'($urandom_range(9));
        u = int'($urandom_range(9));
        bcd1    = t[3:0];
        bcd0    = u[3:0];
        cur_exp = ref_bin(t, u);
        start   = 1'b1;
        dcount  = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            check("hold_done_pattern", {6'd0, done_tick}, {6'd0, (k % 9 == 8)});
            check("hold_ready_pattern", {6'd0, ready}, {6'd0, (k % 9 == 0)});
            if (done_tick) dcount++;
            if (k % 9 == 8) begin
                check("hold_bin", bin, cur_exp);
            end
            if (k % 9 == 0) begin
                t = int'($urandom_range(9));
                u = int'($urandom_range(9));
                bcd1     = t[3:0];
                bcd0     = u[3:0];
                next_exp = ref_bin(t, u);
                cur_exp  = next_exp;
            end
        end
        check("hold_done_count", 7'(dcount), 7'd4);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_release_idle", {6'd0, ready}, 7'd1);

        // Reset during the third iteration aborts without a done_tick.
        bcd1  = 4'd8;
        bcd0  = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_busy", {6'd0, ready}, 7'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", {6'd0, ready}, 7'd1);
        check("abort_bin", bin, 7'd0);
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_tick) dcount++;
            @(negedge clk);
        end
        check("abort_no_done", 7'(dcount), 7'd0);
        check("abort_bin_hold", bin, 7'd0);

        // Normal operation resumes after the abort.
        run_conv(6, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
